// File: rtl/chan_tx_arbiter_pkg.sv
// Shared types and defaults for the channel tx arbiter.
// Optional watchdog is enabled with the CHAN_ARB_WATCHDOG_EN macro (see chan_tx_arbiter.sv).
package chan_tx_arbiter_pkg;

    localparam int unsigned NUM_CHAN_DEF = 4;
    localparam int unsigned CHAN_W_DEF   = 2;
    localparam int unsigned HOLD_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/chan_tx_arbiter_rr_select.sv
// Combinational round-robin picker: first requesting index after i_last, wrapping.
module chan_tx_arbiter_rr_select
    import chan_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CHAN = NUM_CHAN_DEF,
    parameter int unsigned CHAN_W   = CHAN_W_DEF
) (
    input  logic [NUM_CHAN-1:0] i_req,
    input  logic [CHAN_W-1:0]   i_last,
    output logic [CHAN_W-1:0]   o_idx,
    output logic                o_valid
);

    logic [CHAN_W-1:0] w_k;

    // Scan offsets 1..NUM_CHAN so i_last itself is checked last.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_k     = '0;
        for (int unsigned off = 1; off <= NUM_CHAN; off++) begin
            w_k = CHAN_W'((32'(i_last) + off) % NUM_CHAN);
            if (!o_valid && i_req[w_k]) begin
                o_valid = 1'b1;
                o_idx   = w_k;
            end
        end
    end

endmodule

// File: rtl/chan_tx_arbiter.sv
// Round-robin arbiter granting one channel FIFO reader at a time onto the tx chain.
// Define CHAN_ARB_WATCHDOG_EN to add the max_hold strobe watchdog (timeout tied low otherwise).
module chan_tx_arbiter
    import chan_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CHAN = NUM_CHAN_DEF,
    parameter int unsigned CHAN_W   = CHAN_W_DEF
) (
    input  logic                  tx_clock,
    input  logic                  reset,
    input  logic [NUM_CHAN-1:0]   pkt_waiting,
    input  logic [NUM_CHAN-1:0]   chan_skip,
    input  logic [NUM_CHAN-1:0]   chan_burst,
    input  logic                  tx_strobe,
    input  logic [HOLD_CNT_W-1:0] max_hold,
    output logic [NUM_CHAN-1:0]   grant,
    output logic [CHAN_W-1:0]     active_chan,
    output logic                  busy,
    output logic                  timeout
);

    arb_state_e            r_state;
    logic [NUM_CHAN-1:0]   r_grant;
    logic [CHAN_W-1:0]     r_active_chan;
    logic [CHAN_W-1:0]     r_last_chan;
    logic                  r_busy;

    arb_state_e            w_state_nxt;
    logic [NUM_CHAN-1:0]   w_grant_nxt;
    logic [CHAN_W-1:0]     w_active_nxt;
    logic [CHAN_W-1:0]     w_last_nxt;
    logic                  w_release;
    logic [CHAN_W-1:0]     w_rr_idx;
    logic                  w_rr_valid;
    logic                  w_skip_g;
    logic                  w_burst_g;

`ifdef CHAN_ARB_WATCHDOG_EN
    logic [HOLD_CNT_W-1:0] r_hold_cnt;
    logic                  r_timeout;
    logic [HOLD_CNT_W-1:0] w_cnt_nxt;
    logic [HOLD_CNT_W-1:0] w_cnt_inc;
    logic                  w_wdog_hit;
    logic                  w_timeout_nxt;

    // Saturating increment so a lowered max_hold can never be skipped past by wrap.
    assign w_cnt_inc  = (r_hold_cnt == '1) ? r_hold_cnt : r_hold_cnt + HOLD_CNT_W'(1);
    assign w_wdog_hit = tx_strobe && (max_hold != '0) && (w_cnt_inc >= max_hold);
`else
    logic w_unused;
    assign w_unused = ^{tx_strobe, max_hold};
`endif

    chan_tx_arbiter_rr_select #(
        .NUM_CHAN (NUM_CHAN),
        .CHAN_W   (CHAN_W)
    ) rr_select (
        .i_req   (pkt_waiting),
        .i_last  (r_last_chan),
        .o_idx   (w_rr_idx),
        .o_valid (w_rr_valid)
    );

    assign w_skip_g  = chan_skip[r_active_chan];
    assign w_burst_g = chan_burst[r_active_chan];

    always_ff @(posedge tx_clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_active_chan <= '0;
            r_last_chan   <= CHAN_W'(NUM_CHAN - 1);
            r_busy        <= 1'b0;
`ifdef CHAN_ARB_WATCHDOG_EN
            r_hold_cnt    <= '0;
            r_timeout     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_active_chan <= w_active_nxt;
            r_last_chan   <= w_last_nxt;
            r_busy        <= (w_state_nxt == HOLD);
`ifdef CHAN_ARB_WATCHDOG_EN
            r_hold_cnt    <= w_cnt_nxt;
            r_timeout     <= w_timeout_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_active_nxt  = r_active_chan;
        w_last_nxt    = r_last_chan;
        w_release     = 1'b0;
`ifdef CHAN_ARB_WATCHDOG_EN
        w_cnt_nxt     = '0;
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_rr_valid) begin
                    w_state_nxt  = HOLD;
                    w_active_nxt = w_rr_idx;
                    w_grant_nxt  = NUM_CHAN'(1) << w_rr_idx;
                end
            end
            HOLD: begin
                // An open burst keeps the lock across packet boundaries.
                if (w_skip_g && !w_burst_g) begin
                    w_release = 1'b1;
                end
`ifdef CHAN_ARB_WATCHDOG_EN
                if (w_skip_g) begin
                    w_cnt_nxt = '0;
                end else if (tx_strobe) begin
                    w_cnt_nxt = w_cnt_inc;
                end else begin
                    w_cnt_nxt = r_hold_cnt;
                end
                if (w_wdog_hit && !w_release) begin
                    w_release     = 1'b1;
                    w_timeout_nxt = 1'b1;
                end
`endif
                if (w_release) begin
                    w_state_nxt = RELEASE;
                    w_grant_nxt = '0;
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
                w_last_nxt  = r_active_chan;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    assign grant       = r_grant;
    assign active_chan = r_active_chan;
    assign busy        = r_busy;
`ifdef CHAN_ARB_WATCHDOG_EN
    assign timeout     = r_timeout;
`else
    assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_chan_tx_arbiter.sv
// Directed bench for chan_tx_arbiter; expected grants are queued at stimulus time and popped when a grant appears.
module tb_chan_tx_arbiter;

    logic        tx_clock;
    logic        reset;
    logic [3:0]  pkt_waiting;
    logic [3:0]  chan_skip;
    logic [3:0]  chan_burst;
    logic        tx_strobe;
    logic [15:0] max_hold;
    logic [3:0]  grant;
    logic [1:0]  active_chan;
    logic        busy;
    logic        timeout;

    int          n_total;
    int          n_bad;
    int          n_to;
    logic [3:0]  e;
    logic [3:0]  q_exp[$];

    chan_tx_arbiter #(
        .NUM_CHAN (4),
        .CHAN_W   (2)
    ) dut (
        .tx_clock    (tx_clock),
        .reset       (reset),
        .pkt_waiting (pkt_waiting),
        .chan_skip   (chan_skip),
        .chan_burst  (chan_burst),
        .tx_strobe   (tx_strobe),
        .max_hold    (max_hold),
        .grant       (grant),
        .active_chan (active_chan),
        .busy        (busy),
        .timeout     (timeout)
    );

    initial tx_clock = 1'b0;
    always #5 tx_clock = ~tx_clock;

    task automatic tick();
        @(posedge tx_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits up to budget cycles for a grant, then pops and checks the expected one.
    task automatic wait_grant(input string tag, input int budget, output logic [3:0] exp);
        int n;
        int idx;
        n   = 0;
        idx = 0;
        exp = 4'b0000;
        while (grant === 4'b0000 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_sb"}, 32'(q_exp.size() > 0), 32'd1);
        if (q_exp.size() > 0) exp = q_exp.pop_front();
        for (int k = 0; k < 4; k++) if (exp[k]) idx = k;
        chk({tag, "_grant"}, 32'(grant), 32'(exp));
        chk({tag, "_chan"}, 32'(active_chan), 32'(idx));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        n_to        = 0;
        reset       = 1'b1;
        pkt_waiting = 4'b0000;
        chan_skip   = 4'b0000;
        chan_burst  = 4'b0000;
        tx_strobe   = 1'b0;
        max_hold    = 16'd0;
        tick();
        tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_chan", 32'(active_chan), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        repeat (7) tick();

        // Single request, grant next cycle, release then idle
        pkt_waiting = 4'b0001;
        q_exp.push_back(4'b0001);
        tick();
        wait_grant("t1", 0, e);
        pkt_waiting = 4'b0000;
        tick();
        chk("t1_hold", 32'(grant), 32'h1);
        chan_skip = e;
        tick();
        chan_skip = 4'b0000;
        chk("t1_rel", 32'(grant), 32'h0);
        chk("t1_rel_busy", 32'(busy), 32'd0);
        tick();
        chk("t1_idle", 32'(grant), 32'h0);

        // Fresh reset so channel 0 leads the rotation
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // All requesting: order 0,1,2,3,0 with a two-cycle gap
        pkt_waiting = 4'b1111;
        q_exp.push_back(4'b0001);
        q_exp.push_back(4'b0010);
        q_exp.push_back(4'b0100);
        q_exp.push_back(4'b1000);
        q_exp.push_back(4'b0001);
        for (int i = 0; i < 5; i++) begin
            wait_grant("t2", 3, e);
            if (i == 4) pkt_waiting = 4'b0000;
            chan_skip = e;
            tick();
            chan_skip = 4'b0000;
            chk("t2_rel", 32'(grant), 32'h0);
            tick();
            chk("t2_gap", 32'(grant), 32'h0);
        end

        // Burst lock on channel 2 while channel 1 waits
        pkt_waiting = 4'b0100;
        q_exp.push_back(4'b0100);
        wait_grant("t3a", 3, e);
        pkt_waiting = 4'b0010;
        chan_burst  = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            chan_skip = 4'b0100;
            tick();
            chan_skip = 4'b0000;
            chk("t3_lock", 32'(grant), 32'h4);
            tick();
        end
        chan_skip = 4'b0010;
        tick();
        chan_skip = 4'b0000;
        chk("t3_other_skip", 32'(grant), 32'h4);
        chan_burst = 4'b0000;
        chan_skip  = 4'b0100;
        q_exp.push_back(4'b0010);
        tick();
        chan_skip = 4'b0000;
        chk("t3_rel", 32'(grant), 32'h0);
        wait_grant("t3b", 3, e);
        pkt_waiting = 4'b0000;
        chan_skip   = 4'b0010;
        tick();
        chan_skip = 4'b0000;
        tick();

        // Release and a new request in the same cycle
        pkt_waiting = 4'b0100;
        q_exp.push_back(4'b0100);
        wait_grant("t4a", 3, e);
        pkt_waiting = 4'b0000;
        tick();
        chan_skip   = 4'b0100;
        pkt_waiting = 4'b1000;
        q_exp.push_back(4'b1000);
        tick();
        chan_skip = 4'b0000;
        chk("t4_rel", 32'(grant), 32'h0);
        tick();
        chk("t4_idle", 32'(grant), 32'h0);
        tick();
        wait_grant("t4b", 0, e);
        pkt_waiting = 4'b0000;
        chan_skip   = 4'b1000;
        tick();
        chan_skip = 4'b0000;
        tick();

`ifdef CHAN_ARB_WATCHDOG_EN
        // Watchdog fires on the 5th strobe even with a burst open
        max_hold    = 16'd5;
        chan_burst  = 4'b0001;
        pkt_waiting = 4'b0001;
        q_exp.push_back(4'b0001);
        wait_grant("t5a", 3, e);
        pkt_waiting = 4'b0000;
        for (int i = 1; i <= 5; i++) begin
            tx_strobe = 1'b1;
            tick();
            tx_strobe = 1'b0;
            if (i < 5) begin
                chk("t5_no_to_yet", 32'(timeout), 32'd0);
                chk("t5_held", 32'(grant), 32'h1);
                tick();
            end
        end
        chk("t5_to", 32'(timeout), 32'd1);
        chk("t5_drop", 32'(grant), 32'h0);
        tick();
        chk("t5_to_pulse", 32'(timeout), 32'd0);
        chk("t5_idle", 32'(grant), 32'h0);
        chan_burst = 4'b0000;

        max_hold    = 16'd0;
        pkt_waiting = 4'b0001;
        q_exp.push_back(4'b0001);
        wait_grant("t5b", 3, e);
        tx_strobe = 1'b1;
        repeat (1000) begin
            tick();
            if (timeout !== 1'b0) n_to++;
        end
        tx_strobe = 1'b0;
        chk("t5_disabled", 32'(n_to), 32'd0);
        chk("t5_disabled_grant", 32'(grant), 32'h1);
`else
        // Without the watchdog max_hold is ignored and timeout stays low
        max_hold    = 16'd5;
        pkt_waiting = 4'b0001;
        q_exp.push_back(4'b0001);
        wait_grant("t5", 3, e);
        tx_strobe = 1'b1;
        repeat (20) begin
            tick();
            if (timeout !== 1'b0) n_to++;
        end
        tx_strobe = 1'b0;
        chk("t5_no_to", 32'(n_to), 32'd0);
        chk("t5_held", 32'(grant), 32'h1);
`endif
        pkt_waiting = 4'b0000;
        chan_skip   = 4'b0001;
        tick();
        chan_skip = 4'b0000;
        tick();

        // Asynchronous reset mid-HOLD
        pkt_waiting = 4'b0010;
        q_exp.push_back(4'b0010);
        wait_grant("t6a", 3, e);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_grant", 32'(grant), 32'h0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_chan", 32'(active_chan), 32'd0);
        pkt_waiting = 4'b0000;
        tick();
        reset = 1'b0;
        tick();
        pkt_waiting = 4'b1000;
        q_exp.push_back(4'b1000);
        wait_grant("t6b", 3, e);
        pkt_waiting = 4'b0000;

        chk("sb_drained", 32'(q_exp.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
